w_clk_ctrl: RTL and testbench
=============================

Name: w_clk_ctrl

Overview:
- Write-clock-domain controller for the asynchronous FIFO; the write-side counterpart of the read-clock controller.
- Generates the write address, the Gray write pointer exported to the read domain, and registered full and almost-full flags.
- Synchronises the read domain's Gray read pointer into w_clk and derives a conservative fill level.
- Adds a sticky overflow flag for debug.

Parameters:
- ADDRESS_SIZE, 4, memory address width; depth DEPTH = 2^ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits. Legal range ≥ 1.
- AFULL_SLACK, 2, almost-full asserts when free slots ≤ AFULL_SLACK. Legal range 1..DEPTH-1.

Ports:
- w_clk  input  1  write clock; all state on its rising edge.
- wrst_n  input  1  asynchronous active-low reset.
- w_en  input  1  write request.
- r_ptr  input  ADDRESS_SIZE+1  Gray read pointer from the read domain (asynchronous to w_clk).
- ovf_clr  input  1  synchronous clear of w_overflow.
- w_inc  output  1  memory write strobe = w_en & !w_full (combinational).
- w_addr  output  ADDRESS_SIZE  memory write address = binary counter LSBs.
- w_ptr  output  ADDRESS_SIZE+1  registered Gray write pointer.
- w_full  output  1  registered full flag.
- w_almost_full  output  1  registered almost-full flag.
- w_level  output  ADDRESS_SIZE+1  registered fill level, range 0..DEPTH.
- w_overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (wrst_n low, asynchronous assert): w_bin, w_ptr, synchroniser stages, w_level, w_full, w_almost_full and w_overflow all 0. w_addr = 0. Release is synchronous to w_clk by system convention.
- Accepted write: w_bnext = w_bin + (w_en & !w_full), modulo 2^(ADDRESS_SIZE+1).
  - w_bin <= w_bnext.
  - w_gnext = w_bnext ^ (w_bnext >> 1).
  - w_ptr <= w_gnext, so w_ptr updates on the same edge that accepts the write.
- Writes while full: ignored. w_bin and w_ptr hold, w_inc = 0.
- Read-pointer synchroniser: two flops, width ADDRESS_SIZE+1, clocked by w_clk, reset by wrst_n. Output is wq2_rptr.
- Full flag:
  - full_next = (w_gnext == {~wq2_rptr[MSB], ~wq2_rptr[MSB-1], wq2_rptr[MSB-2:0]}).
  - For ADDRESS_SIZE = 1, only the two MSBs are inverted.
  - w_full <= full_next.
  - w_full asserts on the edge that accepts the DEPTH-th unread write; no write is ever lost or double-accepted.
- Level:
  - rq_bin = Gray-to-binary of wq2_rptr.
  - level_next = (w_bnext - rq_bin) mod 2^(ADDRESS_SIZE+1).
  - w_level <= level_next.
  - Pessimistic: it lags reads by the synchroniser delay and never under-reports.
- Almost full: w_almost_full <= (level_next ≥ DEPTH - AFULL_SLACK). It is also asserted whenever full.
- Read-release latency: a change on r_ptr (stable before edge 1) is reflected in w_full, w_level and w_almost_full after edge 3: two synchroniser edges plus the flag register.
- Overflow:
  - Set on an edge where w_en & w_full.
  - Cleared on an edge with ovf_clr & !(w_en & w_full).
  - Set wins over a simultaneous clear.
- Wrap-around: the pointers are ADDRESS_SIZE+1 bits wide. w_addr wraps every DEPTH writes; the MSB toggles so full and empty stay distinguishable. Full detection must hold across every lap.
- Simultaneous write and read release on the same edge: the write is evaluated against the current w_full only; freed space becomes usable no earlier than the rule above.
- Reset mid-operation: all state returns to 0 immediately. The read domain must be reset concurrently; if it is not, behaviour is undefined.
- No combinational path from r_ptr to any output.

Test Plan:
- Reset/idle: hold wrst_n = 0 with w_en = 1 → all outputs 0. Release and idle with r_ptr = 0 → w_ptr stays 5'b00000, w_full stays 0.
- Fill (ADDRESS_SIZE = 4, r_ptr = 0):
  - 16 back-to-back writes → w_addr counts 0..15.
  - w_ptr after write 16 = Gray(16) = 5'b11000.
  - w_full = 1 after edge 16, w_level = 16, w_almost_full = 1 from the edge where level reached 14.
- Overflow: full, assert w_en 3 cycles → w_inc = 0 and w_bin unchanged.
  - w_overflow = 1 and stays 1.
  - ovf_clr with w_en = 0 → clears next edge.
  - ovf_clr together with w_en while full → stays 1.
- Read release: full, drive r_ptr = Gray(1) = 5'b00001 → w_full falls exactly 3 edges later and w_level = 15. One more write → w_full = 1 again, w_addr = 0.
- Wrap: stream 40 writes with r_ptr tracking 2 behind via Gray → w_full never asserts. w_addr wraps twice. w_ptr sequence is valid Gray, one bit change per accepted write.
- Mid-operation reset: at level 9, pulse wrst_n low between edges → outputs 0 asynchronously. Next write after release goes to w_addr = 0.

Source files
------------

// File: rtl/w_clk_ctrl.sv
// -----------------------------------------------------------------------------
// w_clk_ctrl : write-clock-domain controller for the asynchronous FIFO.
//
// Owns the write side of the FIFO pointer pair. It counts accepted writes in
// binary, exports the count as a Gray pointer for the read domain, and brings
// the read domain's Gray pointer across a two-flop synchroniser. The full,
// almost-full and fill-level outputs are computed from that synchronised
// pointer, so they are conservative: they catch up with reads late, but they
// never report more free space than there really is.
//
// Ports
//   w_clk          write clock; all state changes on its rising edge
//   wrst_n         asynchronous active-low reset
//   w_en           write request
//   r_ptr          Gray read pointer from the read domain (asynchronous)
//   ovf_clr        synchronous clear of w_overflow
//   w_inc          memory write strobe, w_en & !w_full (combinational)
//   w_addr         memory write address (low bits of the binary counter)
//   w_ptr          registered Gray write pointer exported to the read domain
//   w_full         registered full flag
//   w_almost_full  registered almost-full flag (free slots <= AFULL_SLACK)
//   w_level        registered conservative fill level, 0..DEPTH
//   w_overflow     sticky flag: a write was attempted while full
// -----------------------------------------------------------------------------
module w_clk_ctrl #(
    parameter int ADDRESS_SIZE = 4,
    parameter int AFULL_SLACK  = 2
) (
    input  logic                    w_clk,
    input  logic                    wrst_n,
    input  logic                    w_en,
    input  logic [ADDRESS_SIZE:0]   r_ptr,
    input  logic                    ovf_clr,
    output logic                    w_inc,
    output logic [ADDRESS_SIZE-1:0] w_addr,
    output logic [ADDRESS_SIZE:0]   w_ptr,
    output logic                    w_full,
    output logic                    w_almost_full,
    output logic [ADDRESS_SIZE:0]   w_level,
    output logic                    w_overflow
);

    localparam int PW    = ADDRESS_SIZE + 1;
    localparam int DEPTH = 1 << ADDRESS_SIZE;

    // A full FIFO has the write pointer exactly one lap ahead of the read
    // pointer; in Gray code that is the read pointer with its two MSBs flipped.
    localparam logic [PW-1:0] FULL_MASK    = PW'(2'd3) << (PW - 2);
    localparam logic [PW-1:0] AFULL_THRESH = PW'(DEPTH - AFULL_SLACK);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0] w_bin_r;
    logic [PW-1:0] w_ptr_r;
    logic [PW-1:0] wq1_rptr_r;
    logic [PW-1:0] wq2_rptr_r;
    logic          w_full_r;
    logic          w_afull_r;
    logic [PW-1:0] w_level_r;
    logic          w_ovf_r;

    logic          w_inc_s;
    logic [PW-1:0] w_bnext_s;
    logic [PW-1:0] w_gnext_s;
    logic [PW-1:0] rq_bin_s;
    logic [PW-1:0] level_next_s;
    logic          full_next_s;
    logic          afull_next_s;
    logic          ovf_next_s;

    // Next-state logic for the write counter, flags, level and overflow.
    always_comb begin
        w_inc_s      = w_en & ~w_full_r;
        w_bnext_s    = w_bin_r + {{(PW-1){1'b0}}, w_inc_s};
        w_gnext_s    = bin_to_gray(w_bnext_s);
        rq_bin_s     = gray_to_bin(wq2_rptr_r);
        // Modulo arithmetic across the extra pointer bit gives the true
        // distance even when the write pointer has lapped the read pointer.
        level_next_s = w_bnext_s - rq_bin_s;
        full_next_s  = (w_gnext_s == (wq2_rptr_r ^ FULL_MASK));
        afull_next_s = (level_next_s >= AFULL_THRESH) | full_next_s;
        // A write attempt while full sets the flag and beats a clear.
        if (w_en & w_full_r) begin
            ovf_next_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = w_ovf_r;
        end
    end

    // Two-flop synchroniser bringing the Gray read pointer into w_clk.
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq1_rptr_r <= {PW{1'b0}};
            wq2_rptr_r <= {PW{1'b0}};
        end else begin
            wq1_rptr_r <= r_ptr;
            wq2_rptr_r <= wq1_rptr_r;
        end
    end

    // Write counter, exported Gray pointer and registered status outputs.
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            w_bin_r   <= {PW{1'b0}};
            w_ptr_r   <= {PW{1'b0}};
            w_full_r  <= 1'b0;
            w_afull_r <= 1'b0;
            w_level_r <= {PW{1'b0}};
            w_ovf_r   <= 1'b0;
        end else begin
            w_bin_r   <= w_bnext_s;
            w_ptr_r   <= w_gnext_s;
            w_full_r  <= full_next_s;
            w_afull_r <= afull_next_s;
            w_level_r <= level_next_s;
            w_ovf_r   <= ovf_next_s;
        end
    end

    assign w_inc         = w_inc_s;
    assign w_addr        = w_bin_r[ADDRESS_SIZE-1:0];
    assign w_ptr         = w_ptr_r;
    assign w_full        = w_full_r;
    assign w_almost_full = w_afull_r;
    assign w_level       = w_level_r;
    assign w_overflow    = w_ovf_r;

endmodule

// File: tb/tb_w_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_w_clk_ctrl : self-checking bench for w_clk_ctrl (ADDRESS_SIZE=4, slack 2).
//
// The driver issues one cycle of stimulus per falling edge and pushes the
// expected post-edge outputs into a queue. The reference model counts writes
// and reads as plain integers: the level is writes minus the read count that
// was current two edges earlier, full is level == DEPTH. A separate monitor
// pops one entry per rising edge and compares.
// -----------------------------------------------------------------------------
module tb_w_clk_ctrl;

    localparam int AS    = 4;
    localparam int DEPTH = 16;
    localparam int SLACK = 2;

    logic          w_clk;
    logic          wrst_n;
    logic          w_en;
    logic [AS:0]   r_ptr;
    logic          ovf_clr;
    logic          w_inc;
    logic [AS-1:0] w_addr;
    logic [AS:0]   w_ptr;
    logic          w_full;
    logic          w_almost_full;
    logic [AS:0]   w_level;
    logic          w_overflow;

    w_clk_ctrl #(.ADDRESS_SIZE(AS), .AFULL_SLACK(SLACK)) dut (
        .w_clk         (w_clk),
        .wrst_n        (wrst_n),
        .w_en          (w_en),
        .r_ptr         (r_ptr),
        .ovf_clr       (ovf_clr),
        .w_inc         (w_inc),
        .w_addr        (w_addr),
        .w_ptr         (w_ptr),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_level       (w_level),
        .w_overflow    (w_overflow)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    typedef struct {
        logic          inc;
        logic [AS-1:0] addr;
        logic [AS:0]   ptr;
        logic [AS:0]   prev_ptr;
        logic [AS:0]   level;
        logic          full;
        logic          afull;
        logic          ovf;
    } exp_t;

    exp_t sbq[$];

    int tests = 0;
    int fails = 0;

    // reference model state
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rdq[$];
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;

    function automatic logic [AS:0] gray(input int v);
        logic [AS:0] b;
        b = AS'(0) + (AS+1)'(v % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        wr_cnt = 0;
        rd_cnt = 0;
        rdq    = '{0, 0};
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // One clock of stimulus plus the model's prediction for the next edge.
    task automatic cycle(input bit en, input bit clr);
        exp_t e;
        int   vis;
        int   lvl;
        @(negedge w_clk);
        w_en    = en;
        ovf_clr = clr;
        r_ptr   = gray(rd_cnt);
        e.prev_ptr = gray(wr_cnt);
        e.inc      = en && !m_full;
        if (e.inc) wr_cnt++;
        vis = rdq.pop_front();
        rdq.push_back(rd_cnt);
        lvl = wr_cnt - vis;
        if (en && m_full) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        m_full  = (lvl == DEPTH);
        e.addr  = (AS)'(wr_cnt % DEPTH);
        e.ptr   = gray(wr_cnt);
        e.level = (AS+1)'(lvl);
        e.full  = m_full;
        e.afull = (lvl >= DEPTH - SLACK);
        e.ovf   = m_ovf;
        sbq.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge w_clk);
        #2;
    endtask

    // Monitor: w_inc just before the edge, registered outputs just after it.
    initial begin
        exp_t e;
        logic inc_s;
        forever begin
            @(negedge w_clk);
            #4;
            inc_s = w_inc;
            @(posedge w_clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("w_inc",         inc_s,         e.inc);
                chk("w_addr",        w_addr,        e.addr);
                chk("w_ptr",         w_ptr,         e.ptr);
                chk("w_level",       w_level,       e.level);
                chk("w_full",        w_full,        e.full);
                chk("w_almost_full", w_almost_full, e.afull);
                chk("w_overflow",    w_overflow,    e.ovf);
                if (e.inc) chk("gray_step", $countones(w_ptr ^ e.prev_ptr), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst_n  = 1'b0;
        w_en    = 1'b1;
        ovf_clr = 1'b0;
        r_ptr   = '0;
        model_reset();

        // reset held across an edge with w_en high
        #12;
        chk("rst_addr",  w_addr, 0);
        chk("rst_ptr",   w_ptr, 0);
        chk("rst_full",  w_full, 0);
        chk("rst_afull", w_almost_full, 0);
        chk("rst_level", w_level, 0);
        chk("rst_ovf",   w_overflow, 0);
        @(negedge w_clk);
        w_en   = 1'b0;
        wrst_n = 1'b1;

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

        // fill with the reader idle
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0);
        after_edge();
        chk("fill_full",  w_full, 1);
        chk("fill_level", w_level, 16);
        chk("fill_ptr",   w_ptr, 5'b11000);
        chk("fill_afull", w_almost_full, 1);

        // overflow: blocked writes, sticky flag, clear, set-beats-clear
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        after_edge();
        chk("ovf_set",  w_overflow, 1);
        chk("ovf_addr", w_addr, 0);
        cycle(1'b0, 1'b1);
        after_edge();
        chk("ovf_clr", w_overflow, 0);
        cycle(1'b1, 1'b1);
        after_edge();
        chk("ovf_set_wins", w_overflow, 1);
        cycle(1'b0, 1'b1);

        // read release: full drops exactly three edges after r_ptr moves
        rd_cnt = 1;
        cycle(1'b0, 1'b0);
        after_edge();
        chk("rel_e1_full", w_full, 1);
        cycle(1'b0, 1'b0);
        after_edge();
        chk("rel_e2_full", w_full, 1);
        cycle(1'b0, 1'b0);
        after_edge();
        chk("rel_e3_full",  w_full, 0);
        chk("rel_e3_level", w_level, 15);
        chk("rel_addr",     w_addr, 0);
        cycle(1'b1, 1'b0);
        after_edge();
        chk("refill_full", w_full, 1);

        // drain, then stream 40 writes with the reader two behind
        rd_cnt = wr_cnt;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (wr_cnt - 2 > rd_cnt) rd_cnt = wr_cnt - 2;
            cycle(1'b1, 1'b0);
            after_edge();
            chk("wrap_no_full", w_full, 0);
        end
        chk("wrap_addr", w_addr, 9);

        // reach level 9, then reset between edges
        rd_cnt = wr_cnt;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0);
        after_edge();
        chk("pre_rst_level", w_level, 9);
        wrst_n = 1'b0;
        r_ptr  = '0;
        #1;
        chk("mid_rst_addr",  w_addr, 0);
        chk("mid_rst_ptr",   w_ptr, 0);
        chk("mid_rst_level", w_level, 0);
        chk("mid_rst_afull", w_almost_full, 0);
        chk("mid_rst_full",  w_full, 0);
        #1;
        wrst_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0);
        after_edge();
        chk("post_rst_addr", w_addr, 1);

        // randomized traffic with a reader that never passes the writer
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0 && wr_cnt > rd_cnt)
                rd_cnt = rd_cnt + $urandom_range(1, wr_cnt - rd_cnt);
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
        end
        after_edge();
        chk("sbq_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
